// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e   : sequencer FSM states (RUN, MEM_WAIT, ERR)
//   REG_IDX_W : architectural register index width
//   ZERO_REG  : x0, which never carries a real dependency
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
//   clk_i : clock
//   rst_i : asynchronous active-low clear
//   inc_i : add one this cycle (ignored once the count is all-ones)
//   cnt_o : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Each cycle it
// decides whether PC, IFID, IDEX, EXMEM and MEMWB capture, hold or take a
// bubble, handling load-use hazards, taken-branch squash and a multi-cycle
// data-memory handshake with timeout.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   id_rs1_i/id_rs2_i       : ID source register indices
//   id_use_rs1_i/_rs2_i     : ID instruction actually reads that source
//   ex_memread_i, ex_rd_i   : EX instruction is a load, and its destination
//   ex_br_taken_i           : branch/jump resolved taken in EX
//   mem_req_i, dm_ready_i   : MEM accesses DM / DM completes this cycle
//   dm_req_o                : request to DM
//   *_we_o                  : pipeline register capture enables
//   *_flush_o               : load an all-zero bubble (overrides enable)
//   err_o                   : sticky DM timeout
//   stall_cnt_o/flush_cnt_o : saturating stall / branch-squash counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DM_TIMEOUT = 255,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic                 ex_memread_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_br_taken_i,
    input  logic                 mem_req_i,
    input  logic                 dm_ready_i,
    output logic                 dm_req_o,
    output logic                 pc_we_o,
    output logic                 ifid_we_o,
    output logic                 idex_we_o,
    output logic                 exmem_we_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 memwb_flush_o,
    output logic                 err_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam int WAIT_W = $clog2(DM_TIMEOUT + 1);
    // The wait counter counts not-ready MEM_WAIT cycles; ERR is taken on
    // the edge at which that count reaches DM_TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                err_q, err_d;

    logic                mem_stall;
    logic                lu;
    logic                stall_inc;
    logic                flush_inc;

    // x0 is hard-wired zero, so a load targeting it creates no dependency.
    assign lu = ex_memread_i && (ex_rd_i != ZERO_REG) &&
                ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_stall     = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        dm_req_o      = 1'b0;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_we_o     = 1'b0;
        exmem_we_o    = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        memwb_flush_o = 1'b0;

        case (state_q)
            RUN: begin
                mem_stall = mem_req_i && !dm_ready_i;
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                mem_stall = !dm_ready_i;
                if (dm_ready_i) begin
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (state_d == RUN) begin
            wait_d = '0;
        end

        // Outputs are forced quiet for the whole reset window, not just
        // at the next edge.
        if (!rst_i) begin
            dm_req_o = 1'b0;
        end else if (state_q == ERR) begin
            memwb_flush_o = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything upstream; bubble WB so the instruction
            // sitting in MEMWB is not retired a second time.
            dm_req_o      = mem_req_i;
            memwb_flush_o = 1'b1;
            stall_inc     = 1'b1;
        end else if (ex_br_taken_i) begin
            // Any load-use in ID is moot: that instruction gets squashed.
            dm_req_o      = mem_req_i;
            pc_we_o       = 1'b1;
            ifid_we_o     = 1'b1;
            idex_we_o     = 1'b1;
            exmem_we_o    = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            flush_inc     = 1'b1;
        end else if (lu) begin
            dm_req_o      = mem_req_i;
            idex_we_o     = 1'b1;
            exmem_we_o    = 1'b1;
            idex_flush_o  = 1'b1;
            stall_inc     = 1'b1;
        end else begin
            dm_req_o      = mem_req_i;
            pc_we_o       = 1'b1;
            ifid_we_o     = 1'b1;
            idex_we_o     = 1'b1;
            exmem_we_o    = 1'b1;
        end
    end

    assign err_d = err_q || (state_d == ERR);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int DM_TIMEOUT = 4;
    localparam int CNT_W      = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1, rs2, ex_rd;
    logic             use1, use2, ex_memread, br, mem_req, dm_ready;
    logic             dm_req_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o;
    logic             ifid_flush_o, idex_flush_o, memwb_flush_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
    logic [7:0]       obs_ctrl;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DM_TIMEOUT(DM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_rs1_i      (rs1),
        .id_rs2_i      (rs2),
        .id_use_rs1_i  (use1),
        .id_use_rs2_i  (use2),
        .ex_memread_i  (ex_memread),
        .ex_rd_i       (ex_rd),
        .ex_br_taken_i (br),
        .mem_req_i     (mem_req),
        .dm_ready_i    (dm_ready),
        .dm_req_o      (dm_req_o),
        .pc_we_o       (pc_we_o),
        .ifid_we_o     (ifid_we_o),
        .idex_we_o     (idex_we_o),
        .exmem_we_o    (exmem_we_o),
        .ifid_flush_o  (ifid_flush_o),
        .idex_flush_o  (idex_flush_o),
        .memwb_flush_o (memwb_flush_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o)
    );

    assign obs_ctrl = {dm_req_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o,
                       ifid_flush_o, idex_flush_o, memwb_flush_o};

    int checks = 0;
    int passed = 0;

    // Reference model: timeout flag, whether a DM access is still
    // outstanding, consecutive not-ready cycles, and the two counts.
    bit m_err;
    bit m_wait;
    int m_nr;
    int m_stall;
    int m_flush;

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit m_lu();
        return ex_memread && (ex_rd != 5'd0) &&
               ((use1 && (rs1 == ex_rd)) || (use2 && (rs2 == ex_rd)));
    endfunction

    function automatic bit m_frozen();
        return !m_err && !dm_ready && (mem_req || m_wait);
    endfunction

    // {dm_req, pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, memwb_fl}
    function automatic logic [7:0] exp_ctrl();
        if (!rst)            return 8'b0_0000_000;
        else if (m_err)      return 8'b0_0000_001;
        else if (m_frozen()) return {mem_req, 7'b0000_001};
        else if (br)         return {mem_req, 7'b1111_110};
        else if (m_lu())     return {mem_req, 7'b0011_010};
        else                 return {mem_req, 7'b1111_000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"},  {24'd0, obs_ctrl}, {24'd0, exp_ctrl()});
        check({tag, ".err"},   {31'd0, err_o}, {31'd0, m_err});
        check({tag, ".stall"}, {{(32-CNT_W){1'b0}}, stall_cnt_o}, m_stall);
        check({tag, ".flush"}, {{(32-CNT_W){1'b0}}, flush_cnt_o}, m_flush);
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; ex_rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; ex_memread = 1'b0;
        br = 1'b0; mem_req = 1'b0; dm_ready = 1'b0;
    endtask

    // Entered at posedge+1 with inputs applied; leaves at next posedge+1.
    task automatic step(input string tag);
        bit fr, lu_c;
        #2;
        check_outputs(tag);
        fr   = m_frozen();
        lu_c = m_lu();
        @(posedge clk);
        if (!m_err) begin
            if (fr) begin
                m_nr++;
                m_wait = 1'b1;
                if (m_nr == DM_TIMEOUT + 1) m_err = 1'b1;
            end else begin
                m_nr   = 0;
                m_wait = 1'b0;
            end
            if (fr || (lu_c && !br)) m_stall = sat(m_stall + 1);
            if (br && !fr)           m_flush = sat(m_flush + 1);
        end
        #1;
    endtask

    // Reset asserted and released between clock edges.
    task automatic do_reset(input string tag);
        idle();
        #2;
        rst = 1'b0;
        m_err = 1'b0; m_wait = 1'b0; m_nr = 0; m_stall = 0; m_flush = 0;
        #1;
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".held"});
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;
        do_reset("reset0");

        // Load-use on rs1, then the same hazard against x0.
        ex_memread = 1'b1; ex_rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        step("lu_rs1");
        idle();
        step("after_lu");
        check("lu_cnt", {28'd0, stall_cnt_o}, 32'd1);
        ex_memread = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; use1 = 1'b1;
        step("lu_x0");

        // Branch taken with a simultaneous load-use on rs2.
        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; rs2 = 5'd7; use2 = 1'b1; br = 1'b1;
        step("br_lu");
        idle();
        step("after_br");
        check("br_flush_cnt", {28'd0, flush_cnt_o}, 32'd1);
        check("br_stall_cnt", {28'd0, stall_cnt_o}, 32'd1);

        // Four-cycle DM access: three frozen cycles, advance on the fourth.
        mem_req = 1'b1; dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("dm_wait");
        dm_ready = 1'b1;
        step("dm_ready");
        mem_req = 1'b0; dm_ready = 1'b0;
        step("dm_back_run");
        check("dm_stall_cnt", {28'd0, stall_cnt_o}, 32'd4);

        // Single-cycle DM access.
        mem_req = 1'b1; dm_ready = 1'b1;
        step("dm_1cyc");
        mem_req = 1'b0; dm_ready = 1'b0;
        step("dm_1cyc_after");

        // DM never answers: timeout into ERR, which ignores later ready.
        mem_req = 1'b1; dm_ready = 1'b0;
        for (int i = 0; i < 8; i++) step("dm_timeout");
        dm_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("err_sticky");
        check("err_flag", {31'd0, err_o}, 32'd1);

        do_reset("reset_err");
        step("post_err_run");

        // Reset while in MEM_WAIT; afterwards an idle DM must not stall.
        mem_req = 1'b1; dm_ready = 1'b0;
        step("wait_a");
        step("wait_b");
        do_reset("reset_wait");
        mem_req = 1'b0; dm_ready = 1'b0;
        step("post_wait_run");

        // Stall counter saturation.
        ex_memread = 1'b1; ex_rd = 5'd3; rs1 = 5'd3; use1 = 1'b1;
        for (int i = 0; i < 20; i++) step("lu_sat");
        idle();
        step("sat_after");
        check("stall_sat", {28'd0, stall_cnt_o}, 32'd15);

        do_reset("reset_rand");

        // Randomized traffic with narrow register ranges so hazards collide.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rand_reset");
            end
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            use1       = ($urandom_range(0, 99) < 60);
            use2       = ($urandom_range(0, 99) < 60);
            ex_memread = ($urandom_range(0, 99) < 50);
            br         = ($urandom_range(0, 99) < 20);
            mem_req    = m_wait ? 1'b1 : ($urandom_range(0, 99) < 35);
            dm_ready   = ($urandom_range(0, 99) < 55);
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. Decides each cycle whether PC, IFID, IDEX, EXMEM and MEMWB capture, hold or load a bubble. Covers load-use hazards, taken-branch squash and a multi-cycle data-memory handshake with timeout. Sits beside the hazard/forwarding logic and drives the enable/flush pins of every pipeline register.

## Interface

**Parameters**
- `DM_TIMEOUT`, default 255: maximum consecutive not-ready cycles before the error state.
- `CNT_W`, default 16: width of the performance counters.

**Ports** (name, direction, width, meaning)
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. **Reset is asynchronous and active-low.**
- `id_rs1_i` / `id_rs2_i`, in, 5 each: source register indices in ID.
- `id_use_rs1_i` / `id_use_rs2_i`, in, 1 each: the ID instruction reads that source.
- `ex_memread_i`, in, 1: the EX instruction is a load.
- `ex_rd_i`, in, 5: destination register index in EX.
- `ex_br_taken_i`, in, 1: branch/jump resolved taken in EX.
- `mem_req_i`, in, 1: the MEM instruction accesses DM.
- `dm_ready_i`, in, 1: DM completes the access this cycle.
- `dm_req_o`, out, 1: request to DM.
- `pc_we_o`, `ifid_we_o`, `idex_we_o`, `exmem_we_o`, out, 1 each: capture enables.
- `ifid_flush_o`, `idex_flush_o`, `memwb_flush_o`, out, 1 each: load all-zero bubble. Flush overrides write-enable.
- `err_o`, out, 1: sticky DM timeout.
- `stall_cnt_o`, out, `CNT_W`: stall cycles (saturating).
- `flush_cnt_o`, out, `CNT_W`: branch squashes (saturating).

## Operation

**FSM states: RUN, MEM_WAIT, ERR.**
- RUN → MEM_WAIT when `mem_req_i & !dm_ready_i`.
- MEM_WAIT → RUN when `dm_ready_i`.
- MEM_WAIT → ERR when the wait counter reaches `DM_TIMEOUT` without ready.
- ERR is absorbing until reset.

**Decode terms**
- `mem_stall` = (RUN & `mem_req_i` & !`dm_ready_i`) | (MEM_WAIT & !`dm_ready_i`).
- `lu` = `ex_memread_i` & (`ex_rd_i`≠0) & ((`id_use_rs1_i` & rs1==`ex_rd_i`) | (`id_use_rs2_i` & rs2==`ex_rd_i`)).

**Priority per cycle: ERR > mem_stall > branch > lu > normal.**
- **ERR:** all `_we_o` = 0; `memwb_flush_o` = 1; `dm_req_o` = 0; `err_o` = 1.
- **mem_stall:** PC/IFID/IDEX/EXMEM enables = 0; `memwb_flush_o` = 1, so WB does not retire the same instruction twice. Branch and `lu` are ignored this cycle; they re-evaluate after the freeze.
- **branch (`ex_br_taken_i`):** all enables = 1; `ifid_flush_o` = `idex_flush_o` = 1. A simultaneous `lu` is dropped because its instruction is squashed.
- **lu:** `pc_we_o` = `ifid_we_o` = 0; `idex_flush_o` = 1; EXMEM/MEMWB advance normally.
- **normal:** all enables = 1; all flushes = 0.

**Handshake and counters**
- `dm_req_o` = `mem_req_i` in RUN and MEM_WAIT. It must stay high until `dm_ready_i` and must not drop mid-wait.
- Wait counter (8 bits, or ⌈log2(DM_TIMEOUT+1)⌉ bits) clears on entry to RUN and increments each MEM_WAIT not-ready cycle.
- `stall_cnt_o` increments on every `mem_stall` or `lu` cycle.
- `flush_cnt_o` increments on every taken-branch cycle that is not masked by `mem_stall`.
- Both performance counters saturate at all-ones.

## Timing

- All control outputs are combinational from current inputs and registered state (zero latency). Only the FSM, wait counter, `err_o` and the performance counters are flops.
- While `rst_i` = 0, regardless of clock:
  - state = RUN, counters = 0, `err_o` = 0;
  - all enables = 0, all flushes = 0, `dm_req_o` = 0.
- First edge after reset release: normal operation.
- Single-cycle DM (`dm_ready_i` high with `mem_req_i`) causes no stall and no state change.
- N-cycle DM wait produces exactly N-1 frozen cycles. Everything advances on the ready cycle.
- DM timeout: ERR is entered on the edge where the wait count equals `DM_TIMEOUT`. `err_o` is high from the next cycle.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately (asynchronous).

## Structure

- Shared package `pipe_ctrl_pkg`:
  - state enum `{RUN, MEM_WAIT, ERR}`;
  - `REG_IDX_W` = 5;
  - `ZERO_REG` = 5'd0.
- One natural sub-module, `sat_counter`: parameterised width, increment, asynchronous active-low clear. Instantiated twice for the performance counters.

## Test plan

1. **Load-use on rs1.** `ex_memread_i` = 1, `ex_rd_i` = 5, `id_rs1_i` = 5, `id_use_rs1_i` = 1 → `pc_we_o` = `ifid_we_o` = 0, `idex_flush_o` = 1 for one cycle; `stall_cnt_o` = 1. Repeat with `ex_rd_i` = 0 → no stall.
2. **Branch and load-use together.** `ex_br_taken_i` plus the `lu` condition → `ifid_flush_o` = `idex_flush_o` = 1, `pc_we_o` = 1; `flush_cnt_o` = 1; `stall_cnt_o` unchanged.
3. **DM wait.** `mem_req_i` = 1, `dm_ready_i` low 3 cycles then high → 3 frozen cycles with `memwb_flush_o` = 1 and `dm_req_o` = 1 throughout; advance on the 4th; state back to RUN; `stall_cnt_o` = 3.
4. **DM timeout.** `DM_TIMEOUT` = 4, `dm_ready_i` held 0 → ERR entered; `err_o` = 1 and sticky; `dm_req_o` = 0; all enables 0; a later `dm_ready_i` has no effect.
5. **Reset mid-wait.** Drop `rst_i` during MEM_WAIT between clock edges → outputs go to reset values immediately; after release, state = RUN and counters = 0.
6. **Counter saturation.** `CNT_W` = 4, 20 load-use cycles → `stall_cnt_o` holds 4'hF.
